// File: rtl/sram_ctl_s3board.sv
// Sequences single-word PDP-8 accesses onto the S3 board's 256Kx16 async SRAM (ram1 only).
// Every SRAM strobe, the address and the bus drive enable come straight from flops.
module sram_ctl_s3board #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        we,
  input  logic [14:0] addr,
  input  logic [11:0] wdata,
  output logic [11:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic [17:0] ram_a,
  output logic        ram_oe_n,
  output logic        ram_we_n,
  inout  wire  [15:0] ram1_io,
  output logic        ram1_ce_n,
  output logic        ram1_ub_n,
  output logic        ram1_lb_n,
  output logic        ram2_ce_n,
  output logic        ram2_ub_n,
  output logic        ram2_lb_n
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD       = 3'd1;
  localparam logic [2:0] S_WR_SETUP = 3'd2;
  localparam logic [2:0] S_WR_PULSE = 3'd3;
  localparam logic [2:0] S_WR_HOLD  = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);

  logic [2:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] rdata_q, rdata_d;
  logic        ack_q, busy_q;
  logic        ce_n_q, oe_n_q, we_n_q, drv_q;
  logic        sel_d, oe_d, we_d, drv_d;
  logic [3:0]  unused_io_hi;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          wdata_d = wdata;
          if (we) begin
            state_d = S_WR_SETUP;
          end else begin
            state_d = S_RD;
            cnt_d   = RD_LOAD;
          end
        end
      end
      S_RD: begin
        // Capture on the edge that ends the last read cycle; bits 15:12 are not part of a PDP-8 word.
        if (cnt_q == 4'd0) begin
          rdata_d = ram1_io[11:0];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WR_SETUP: begin
        state_d = S_WR_PULSE;
        cnt_d   = WR_LOAD;
      end
      S_WR_PULSE: begin
        if (cnt_q == 4'd0) state_d = S_WR_HOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WR_HOLD: state_d = S_DONE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    sel_d = (state_d == S_RD) || (state_d == S_WR_SETUP) ||
            (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
    oe_d  = (state_d == S_RD);
    we_d  = (state_d == S_WR_PULSE);
    drv_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) || (state_d == S_WR_HOLD);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 15'd0;
      wdata_q <= 12'd0;
      rdata_q <= 12'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
      ce_n_q  <= !sel_d;
      oe_n_q  <= !oe_d;
      we_n_q  <= !we_d;
      drv_q   <= drv_d;
    end
  end

  assign ram1_io      = drv_q ? {4'b0000, wdata_q} : 16'hzzzz;
  assign unused_io_hi = ram1_io[15:12];

  assign rdata     = rdata_q;
  assign ack       = ack_q;
  assign busy      = busy_q;
  assign ram_a     = {3'b000, addr_q};
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign ram1_ce_n = ce_n_q;
  assign ram1_ub_n = ce_n_q;
  assign ram1_lb_n = ce_n_q;
  assign ram2_ce_n = 1'b1;
  assign ram2_ub_n = 1'b1;
  assign ram2_lb_n = 1'b1;

endmodule

// File: tb/tb_sram_ctl_s3board.sv
// Bench for sram_ctl_s3board: behavioural 256Kx16 SRAM model, shadow word memory,
// expected-rdata queue popped on every ack, per-cycle pin monitor.
module tb_sram_ctl_s3board;

  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [14:0] addr = '0;
  logic [11:0] wdata = '0;
  wire  [11:0] rdata;
  wire         ack, busy;
  wire  [17:0] ram_a;
  wire         ram_oe_n, ram_we_n;
  wire  [15:0] ram1_io;
  wire         ram1_ce_n, ram1_ub_n, ram1_lb_n;
  wire         ram2_ce_n, ram2_ub_n, ram2_lb_n;

  sram_ctl_s3board #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ack(ack), .busy(busy), .ram_a(ram_a),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n), .ram1_io(ram1_io),
    .ram1_ce_n(ram1_ce_n), .ram1_ub_n(ram1_ub_n), .ram1_lb_n(ram1_lb_n),
    .ram2_ce_n(ram2_ce_n), .ram2_ub_n(ram2_ub_n), .ram2_lb_n(ram2_lb_n)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [7:0] mem_h [0:262143];
  logic [7:0] mem_l [0:262143];

  assign ram1_io = (!ram1_ce_n && !ram_oe_n) ? {mem_h[ram_a], mem_l[ram_a]} : 16'hzzzz;

  always @(posedge clk) begin
    if (reset_n && !ram1_ce_n && !ram_we_n) begin
      if (!ram1_ub_n) mem_h[ram_a] = ram1_io[15:8];
      if (!ram1_lb_n) mem_l[ram_a] = ram1_io[7:0];
    end
  end

  // ---------------- scoreboard state ----------------
  logic [11:0] exp_q[$];
  logic [11:0] shadow [0:32767];
  logic [11:0] last_rdata = '0;
  logic [14:0] cur_addr = '0;
  logic [11:0] cur_wdata = '0;
  int          we_low_cnt = 0;
  logic        ack_prev = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      check("oe_we_exclusive", 32'(!ram_we_n && !ram_oe_n), 0);
      check("ram2_idle", {ram2_ce_n, ram2_ub_n, ram2_lb_n}, 3'b111);
      check("byte_en_follow_ce", {ram1_ub_n, ram1_lb_n}, {ram1_ce_n, ram1_ce_n});
      check("ram_a_value", ram_a, {3'b000, cur_addr});
      if (!ram_oe_n) check("rd_strobes", {ram1_ce_n, ram_we_n}, 2'b01);
      if (!ram1_ce_n && ram_oe_n) check("wr_bus_data", ram1_io, {4'b0000, cur_wdata});
      if (!ram_we_n) we_low_cnt++;
      check("ack_width", 32'(ack_prev && ack), 0);
      ack_prev = ack;
      if (ack) begin
        if (exp_q.size() == 0) check("ack_unexpected", 1, 0);
        else check("rdata", rdata, exp_q.pop_front());
      end
    end else begin
      ack_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  // Latency = posedges after the req-sampling edge up to the first edge that sees ack high.
  task automatic wait_ack(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (ack) break;
    end
    if (!ack) check("ack_timeout", 0, 1);
  endtask

  task automatic preload(input logic [14:0] a, input logic [11:0] d);
    mem_h[{3'b000, a}] = {4'b0000, d[11:8]};
    mem_l[{3'b000, a}] = d[7:0];
    shadow[a] = d;
  endtask

  task automatic do_access(input bit w, input logic [14:0] a, input logic [11:0] d,
                           input logic [11:0] exp_rd, input string tag);
    int lat;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d;
    exp_q.push_back(exp_rd);
    if (w) shadow[a] = d;
    last_rdata = exp_rd;
    @(posedge clk);
    cur_addr = a;
    if (w) cur_wdata = d;
    we_low_cnt = 0;
    // Scramble inputs once sampled: the access in flight must not notice.
    #1 req = 1'b0; we = !w; addr = ~a; wdata = ~d;
    wait_ack(lat);
    check({tag, "_latency"}, lat, w ? WR_WAIT + 3 : RD_WAIT + 1);
    check({tag, "_we_low_cycles"}, we_low_cnt, w ? WR_WAIT : 0);
  endtask

  typedef struct {
    bit          w;
    logic [14:0] a;
    logic [11:0] d;
    logic [11:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  // ---------------- main sequence ----------------
  initial begin
    int          lat, k;
    logic [15:0] word;
    logic [11:0] prior;
    bit          w;
    logic [14:0] a;
    logic [11:0] d;

    vecs[0] = '{1'b1, 15'o07777, 12'o7777, 12'o1234};
    vecs[1] = '{1'b1, 15'o00000, 12'o0000, 12'o1234};
    vecs[2] = '{1'b0, 15'o07777, 12'o0000, 12'o7777};
    vecs[3] = '{1'b0, 15'o00000, 12'o0000, 12'o0000};
    vecs[4] = '{1'b1, 15'o77777, 12'o5252, 12'o0000};
    vecs[5] = '{1'b0, 15'o77777, 12'o0000, 12'o5252};
    vecs[6] = '{1'b0, 15'o00100, 12'o0000, 12'o4567};
    vecs[7] = '{1'b0, 15'o00003, 12'o0000, 12'o0000};

    for (int i = 0; i < 262144; i++) begin
      mem_h[i] = 8'h00;
      mem_l[i] = 8'h00;
    end
    for (int i = 0; i < 32768; i++) shadow[i] = 12'o0000;

    // reset
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", rdata, 0);
    check("reset_ack_busy", {ack, busy}, 2'b00);
    check("reset_ram_a", ram_a, 0);
    check("reset_strobes", {ram_oe_n, ram_we_n, ram1_ce_n, ram1_ub_n, ram1_lb_n}, 5'b11111);
    @(negedge clk);
    reset_n = 1'b1;

    // preloaded read
    preload(15'o00100, 12'o4567);
    do_access(1'b0, 15'o00100, 12'o0000, 12'o4567, "rd_preload");

    // write then read back, byte lanes in the model
    do_access(1'b1, 15'o70123, 12'o1234, last_rdata, "wr_70123");
    check("wr_70123_ram_a", ram_a, 18'o070123);
    check("wr_70123_ram_h", mem_h[18'o070123], 8'h02);
    check("wr_70123_ram_l", mem_l[18'o070123], 8'h9C);
    do_access(1'b0, 15'o70123, 12'o0000, 12'o1234, "rd_70123");

    // table vectors
    for (int i = 0; i < 8; i++)
      do_access(vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].exp_rd, $sformatf("vec%0d", i));

    // req held high: write 00001=0001 then read 00001
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 15'o00001; wdata = 12'o0001;
    exp_q.push_back(last_rdata);
    shadow[15'o00001] = 12'o0001;
    @(posedge clk);
    cur_addr = 15'o00001; cur_wdata = 12'o0001; we_low_cnt = 0;
    #1 we = 1'b0;
    wait_ack(lat);
    check("held_wr_latency", lat, WR_WAIT + 3);
    check("held_wr_busy_in_done", busy, 1);
    exp_q.push_back(12'o0001);
    last_rdata = 12'o0001;
    @(negedge clk);
    check("held_busy_gap", {busy, ack}, 2'b00);
    @(posedge clk);
    #1 req = 1'b0;
    wait_ack(lat);
    check("held_rd_latency", lat, RD_WAIT + 1);

    // reset during the write pulse
    prior = shadow[15'o00200];
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 15'o00200; wdata = 12'o3333;
    @(posedge clk);
    cur_addr = 15'o00200; cur_wdata = 12'o3333;
    #1 req = 1'b0;
    k = 0;
    while (ram_we_n && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("abort_reached_pulse", ram_we_n, 0);
    #2 reset_n = 1'b0;
    cur_addr = '0;
    last_rdata = '0;
    #1;
    check("abort_strobes", {ram_we_n, ram1_ce_n, ram_oe_n, ram1_ub_n, ram1_lb_n}, 5'b11111);
    check("abort_busy_ack", {busy, ack}, 2'b00);
    check("abort_ram_a", ram_a, 0);
    repeat (3) begin
      @(negedge clk);
      check("abort_no_ack", ack, 0);
    end
    reset_n = 1'b1;
    word = {mem_h[18'o000200], mem_l[18'o000200]};
    check("abort_word_legal", 32'(word[11:0] == prior || word[11:0] == 12'o3333), 1);
    shadow[15'o00200] = word[11:0];
    do_access(1'b0, 15'o00200, 12'o0000, word[11:0], "rd_after_abort");
    do_access(1'b1, 15'o00200, 12'o3333, last_rdata, "rewrite_200");
    do_access(1'b0, 15'o00200, 12'o0000, 12'o3333, "reread_200");

    // random traffic against the shadow memory
    for (int i = 0; i < 1000; i++) begin
      w = 1'($urandom_range(0, 1));
      a = {3'($urandom_range(0, 7)), 7'd0, 5'($urandom_range(0, 31))};
      d = 12'($urandom_range(0, 4095));
      do_access(w, a, d, w ? last_rdata : shadow[a], "rand");
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/sram_ctl_s3board.md
Name: sram_ctl_s3board

Overview:
- Synchronous initiator for the on-board 256Kx16 asynchronous SRAM pair of the S3 board.
- Converts a single-word request/acknowledge handshake from the PDP-8 memory path into correctly sequenced SRAM strobes.
- Services 12-bit PDP-8 words, using ram1 only, over 15-bit field+address space.
- Sits between the CPU memory interface and the board SRAM pins (or the SRAM simulation model in the bench).

Parameters:
RD_WAIT, 2, cycles ce_n/oe_n held low before read data is captured (legal range 1..15)
WR_WAIT, 2, cycles we_n held low during a write pulse (legal range 1..15)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
req  input  1  request; sampled only in IDLE
we  input  1  1 = write, 0 = read; sampled with req
addr  input  15  {field[2:0], addr[11:0]} word address; sampled with req
wdata  input  12  write data; sampled with req
rdata  output  12  read data; holds last captured value
ack  output  1  one-cycle completion pulse
busy  output  1  high whenever state != IDLE
ram_a  output  18  SRAM address = {3'b000, latched addr}
ram_oe_n  output  1  SRAM output enable, active low
ram_we_n  output  1  SRAM write enable, active low
ram1_io  inout  16  ram1 data bus; driven {4'b0000, wdata} only in WR_SETUP/WR_PULSE/WR_HOLD, else high-Z
ram1_ce_n  output  1  ram1 chip enable
ram1_ub_n  output  1  ram1 upper byte enable
ram1_lb_n  output  1  ram1 lower byte enable
ram2_ce_n  output  1  ram2 chip enable, constant 1
ram2_ub_n  output  1  constant 1
ram2_lb_n  output  1  constant 1

Behaviour:
- Reset (async, reset_n=0): state IDLE; ram_a=0, rdata=0, ack=0, busy=0, ram_oe_n=ram_we_n=ram1_ce_n=ram1_ub_n=ram1_lb_n=1, ram1_io high-Z. Reset mid-operation aborts immediately, with strobes deasserted asynchronously and no ack.
- All strobe outputs are registered. No combinational path from req to any SRAM pin.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE. A 4-bit wait counter is loaded on entry to RD and WR_PULSE.
- IDLE: on req=1 at an edge:
  - latch addr, wdata and we;
  - go to RD if we=0, else WR_SETUP.
- RD: ram1_ce_n=0, ram1_ub_n=ram1_lb_n=0, ram_oe_n=0, ram_we_n=1.
  - Stay RD_WAIT cycles.
  - On the edge leaving the last RD cycle, rdata <= ram1_io[11:0]; bits 15:12 are ignored.
  - Go to DONE.
- WR_SETUP: 1 cycle. ce_n=0, ub_n=lb_n=0, address and data valid, we_n=1, oe_n=1.
- WR_PULSE: WR_WAIT cycles with we_n=0. Address and data remain stable.
- WR_HOLD: 1 cycle with we_n=1. ce_n, address and data still held, so data hold time exceeds we_n rise.
- DONE: 1 cycle. ack=1; ce_n, oe_n, we_n, ub_n and lb_n all = 1; bus high-Z. Always returns to IDLE.
- Latency, counted from the req-sampling edge to ack high:
  - read: RD_WAIT+1 cycles;
  - write: WR_WAIT+3 cycles.
- Handshake:
  - req is ignored outside IDLE; a held req starts a new access in the cycle after DONE.
  - Back-to-back throughput: one access per latency+1 cycles.
  - addr, we and wdata changes after sampling have no effect on the access in progress.
- ram_we_n and ram_oe_n are never low simultaneously.
- ram1_io is never driven while ram_oe_n=0.
- ram_a changes only in IDLE→RD/WR_SETUP transitions; it holds its value otherwise, including after DONE.
- rdata is unchanged by writes.

Test Plan:
- Preload ram1 word 00100=04567, read addr=15'o00100 (RD_WAIT=2) → ack exactly 3 cycles after sampling edge, rdata=12'o4567, ram_we_n stays 1 throughout.
- Write addr=15'o70123 wdata=12'o1234 (WR_WAIT=2), then read the same address → ram_a=18'o070123, we_n low exactly 2 cycles, model ram_h/ram_l = 8'h02/8'h9C, read returns 12'o1234, write ack at 5 cycles.
- req held high across write to 00001=0001 and read of 00001 → second access begins the cycle after DONE, read returns 0001, ack pulses are 1 cycle wide, busy drops for exactly 1 cycle between accesses.
- Assert reset_n=0 during WR_PULSE → within the same cycle ram_we_n=ram1_ce_n=1 and ram1_io=Z; no ack; subsequent read of that address returns either the prior or new value, never X on bits 11:0 after a clean rewrite.
- Monitor every cycle across 1000 random reads and writes → never (ram_we_n=0 and ram_oe_n=0); ram1_io is Z whenever ram_oe_n=0; ram2_ce_n=1 always; reads match a shadow memory model.
